regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 90 +++++++++
 tb/tb_regfile_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter
// Brief    : Two-client arbiter in front of an 8x8 register file, with a
//            one-cycle tagged read response returned to the granted client.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       c0_valid,
    output logic       c0_ready,
    input  logic       c0_we,
    input  logic [2:0] c0_rs1,
    input  logic [2:0] c0_rs2,
    input  logic [2:0] c0_rd,
    input  logic [7:0] c0_wdata,
    output logic       c0_rsp_valid,

    input  logic       c1_valid,
    output logic       c1_ready,
    input  logic       c1_we,
    input  logic [2:0] c1_rs1,
    input  logic [2:0] c1_rs2,
    input  logic [2:0] c1_rd,
    input  logic [7:0] c1_wdata,
    output logic       c1_rsp_valid,

    output logic [7:0] rsp_data1,
    output logic [7:0] rsp_data2,

    output logic       rf_write_enable,
    output logic [2:0] rf_write_reg,
    output logic [7:0] rf_write_data,
    output logic [2:0] rf_read_reg1,
    output logic [2:0] rf_read_reg2,
    input  logic [7:0] rf_read_data1,
    input  logic [7:0] rf_read_data2
);

    // 1 when client 1 holds the most recent grant, so client 0 wins next contention
    logic r_last_grant;
    logic r_rsp_valid;
    logic r_rsp_id;

    logic w_c0_wins;
    logic w_grant0;
    logic w_grant1;

    always_comb begin
        w_c0_wins = (RR_ENABLE == 0) || r_last_grant;
        w_grant0  = !rst && c0_valid && (!c1_valid || w_c0_wins);
        w_grant1  = !rst && c1_valid && !w_grant0;
    end

    assign c0_ready = w_grant0;
    assign c1_ready = w_grant1;

    // Address/data follow client 0 when nothing is granted; only the enable matters then
    assign rf_read_reg1    = w_grant1 ? c1_rs1   : c0_rs1;
    assign rf_read_reg2    = w_grant1 ? c1_rs2   : c0_rs2;
    assign rf_write_reg    = w_grant1 ? c1_rd    : c0_rd;
    assign rf_write_data   = w_grant1 ? c1_wdata : c0_wdata;
    assign rf_write_enable = (w_grant0 && c0_we) || (w_grant1 && c1_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
        end else begin
            r_rsp_valid <= w_grant0 || w_grant1;
            r_rsp_id    <= w_grant1;
            if (w_grant0 || w_grant1) begin
                r_last_grant <= w_grant1;
            end
        end
    end

    // Gating with rst drops a response still pending when reset arrives
    assign c0_rsp_valid = !rst && r_rsp_valid && !r_rsp_id;
    assign c1_rsp_valid = !rst && r_rsp_valid &&  r_rsp_id;
    assign rsp_data1    = rf_read_data1;
    assign rsp_data2    = rf_read_data2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_arbiter
// Brief    : Directed self-checking bench for regfile_arbiter (round-robin and
//            fixed-priority instances driven with the same client stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c0_valid = 1'b0, c0_we = 1'b0;
    logic [2:0] c0_rs1 = 3'd0, c0_rs2 = 3'd0, c0_rd = 3'd0;
    logic [7:0] c0_wdata = 8'h00;
    logic       c1_valid = 1'b0, c1_we = 1'b0;
    logic [2:0] c1_rs1 = 3'd0, c1_rs2 = 3'd0, c1_rd = 3'd0;
    logic [7:0] c1_wdata = 8'h00;

    logic       c0_ready, c1_ready, c0_rsp_valid, c1_rsp_valid;
    logic [7:0] rsp_data1, rsp_data2;
    logic       rf_write_enable;
    logic [2:0] rf_write_reg, rf_read_reg1, rf_read_reg2;
    logic [7:0] rf_write_data;
    logic [7:0] rf_rd1, rf_rd2;

    logic       fp_c0_ready, fp_c1_ready, fp_c0_rsp_valid, fp_c1_rsp_valid;
    logic [7:0] fp_rsp_data1, fp_rsp_data2;
    logic       fp_we;
    logic [2:0] fp_wreg, fp_rreg1, fp_rreg2;
    logic [7:0] fp_wdata;
    logic [7:0] fp_rd1 = 8'h00, fp_rd2 = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.RR_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_we(c0_we), .c0_rs1(c0_rs1),
        .c0_rs2(c0_rs2), .c0_rd(c0_rd), .c0_wdata(c0_wdata), .c0_rsp_valid(c0_rsp_valid),
        .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_we(c1_we), .c1_rs1(c1_rs1),
        .c1_rs2(c1_rs2), .c1_rd(c1_rd), .c1_wdata(c1_wdata), .c1_rsp_valid(c1_rsp_valid),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data), .rf_read_reg1(rf_read_reg1),
        .rf_read_reg2(rf_read_reg2), .rf_read_data1(rf_rd1), .rf_read_data2(rf_rd2)
    );

    regfile_arbiter #(.RR_ENABLE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .c0_valid(c0_valid), .c0_ready(fp_c0_ready), .c0_we(c0_we), .c0_rs1(c0_rs1),
        .c0_rs2(c0_rs2), .c0_rd(c0_rd), .c0_wdata(c0_wdata), .c0_rsp_valid(fp_c0_rsp_valid),
        .c1_valid(c1_valid), .c1_ready(fp_c1_ready), .c1_we(c1_we), .c1_rs1(c1_rs1),
        .c1_rs2(c1_rs2), .c1_rd(c1_rd), .c1_wdata(c1_wdata), .c1_rsp_valid(fp_c1_rsp_valid),
        .rsp_data1(fp_rsp_data1), .rsp_data2(fp_rsp_data2),
        .rf_write_enable(fp_we), .rf_write_reg(fp_wreg),
        .rf_write_data(fp_wdata), .rf_read_reg1(fp_rreg1),
        .rf_read_reg2(fp_rreg2), .rf_read_data1(fp_rd1), .rf_read_data2(fp_rd2)
    );

    // Register file model: synchronous write, registered reads returning pre-write data
    logic [7:0] mem [8];
    always @(posedge clk) begin
        rf_rd1 <= mem[rf_read_reg1];
        rf_rd2 <= mem[rf_read_reg2];
        if (rf_write_enable) mem[rf_write_reg] <= rf_write_data;
    end

    task automatic idle();
        c0_valid = 1'b0; c0_we = 1'b0;
        c1_valid = 1'b0; c1_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        c0_valid = 1'b1; c0_we = 1'b1; c1_valid = 1'b1; c1_we = 1'b1;
        #1;
        checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL reset_c0_ready got %b want 0", c0_ready); end
        checks++; if (c1_ready !== 1'b0) begin errors++; $display("FAIL reset_c1_ready got %b want 0", c1_ready); end
        checks++; if (rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_write_enable); end
        @(negedge clk); #1;
        checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp got %b want 00", {c0_rsp_valid, c1_rsp_valid}); end
        checks++; if ({fp_c0_ready, fp_c1_ready} !== 2'b00) begin errors++; $display("FAIL reset_fp_ready got %b want 00", {fp_c0_ready, fp_c1_ready}); end
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        c0_valid = 1'b1; c0_we = 1'b1; c0_rd = 3'd3; c0_wdata = 8'h5A;
        #1;
        checks++; if (c0_ready !== 1'b1) begin errors++; $display("FAIL wr_c0_ready got %b want 1", c0_ready); end
        checks++; if ({rf_write_enable, rf_write_reg, rf_write_data} !== {1'b1, 3'd3, 8'h5A})
            begin errors++; $display("FAIL wr_port got %b/%0d/%h want 1/3/5a", rf_write_enable, rf_write_reg, rf_write_data); end
        @(negedge clk);
        c0_valid = 1'b0;
        c1_valid = 1'b1; c1_we = 1'b0; c1_rs1 = 3'd3; c1_rs2 = 3'd0;
        #1;
        checks++; if (c1_ready !== 1'b1) begin errors++; $display("FAIL rd_c1_ready got %b want 1", c1_ready); end
        checks++; if (rf_read_reg1 !== 3'd3) begin errors++; $display("FAIL rd_addr got %0d want 3", rf_read_reg1); end
        checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b10) begin errors++; $display("FAIL wr_rsp got %b want 10", {c0_rsp_valid, c1_rsp_valid}); end
        @(negedge clk);
        c1_valid = 1'b0;
        #1;
        checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b01) begin errors++; $display("FAIL rd_rsp got %b want 01", {c0_rsp_valid, c1_rsp_valid}); end
        checks++; if (rsp_data1 !== 8'h5A) begin errors++; $display("FAIL rd_data1 got %h want 5a", rsp_data1); end
        checks++; if (rf_write_enable !== 1'b0) begin errors++; $display("FAIL nogrant_we got %b want 0", rf_write_enable); end
        idle();
    endtask

    task automatic test_no_bypass();
        @(negedge clk);
        c1_valid = 1'b1; c1_we = 1'b1; c1_rd = 3'd2; c1_wdata = 8'h07;
        @(negedge clk);
        c1_valid = 1'b0; c1_we = 1'b0;
        c0_valid = 1'b1; c0_we = 1'b1; c0_rd = 3'd2; c0_wdata = 8'h11; c0_rs1 = 3'd2;
        #1;
        checks++; if ({c0_ready, rf_read_reg1, rf_write_reg, rf_write_data} !== {1'b1, 3'd2, 3'd2, 8'h11})
            begin errors++; $display("FAIL nb_grant got %b/%0d/%0d/%h want 1/2/2/11", c0_ready, rf_read_reg1, rf_write_reg, rf_write_data); end
        @(negedge clk);
        c0_valid = 1'b0; c0_we = 1'b0;
        c1_valid = 1'b1; c1_rs1 = 3'd0; c1_rs2 = 3'd2;
        #1;
        checks++; if (c0_rsp_valid !== 1'b1) begin errors++; $display("FAIL nb_rsp0 got %b want 1", c0_rsp_valid); end
        checks++; if (rsp_data1 !== 8'h07) begin errors++; $display("FAIL nb_old_data got %h want 07", rsp_data1); end
        checks++; if (rf_read_reg2 !== 3'd2) begin errors++; $display("FAIL nb_rs2 got %0d want 2", rf_read_reg2); end
        @(negedge clk);
        c1_valid = 1'b0;
        #1;
        checks++; if (c1_rsp_valid !== 1'b1) begin errors++; $display("FAIL nb_rsp1 got %b want 1", c1_rsp_valid); end
        checks++; if (rsp_data2 !== 8'h11) begin errors++; $display("FAIL nb_new_data got %h want 11", rsp_data2); end
        idle();
    endtask

    task automatic test_round_robin();
        logic exp0;
        @(negedge clk);
        c0_valid = 1'b1;
        #1;
        checks++; if (c0_ready !== 1'b1) begin errors++; $display("FAIL rr_pre got %b want 1", c0_ready); end
        @(negedge clk);
        rst = 1'b1; c0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        c0_valid = 1'b1; c0_rs1 = 3'd1; c1_valid = 1'b1; c1_rs1 = 3'd5;
        for (int i = 0; i < 4; i++) begin
            exp0 = (i % 2 == 0);
            #1;
            checks++; if ({c0_ready, c1_ready} !== {exp0, !exp0})
                begin errors++; $display("FAIL rr_grant%0d got %b want %b", i, {c0_ready, c1_ready}, {exp0, !exp0}); end
            checks++; if (rf_read_reg1 !== (exp0 ? 3'd1 : 3'd5))
                begin errors++; $display("FAIL rr_addr%0d got %0d want %0d", i, rf_read_reg1, exp0 ? 1 : 5); end
            checks++; if ({fp_c0_ready, fp_c1_ready} !== 2'b10)
                begin errors++; $display("FAIL fp_grant%0d got %b want 10", i, {fp_c0_ready, fp_c1_ready}); end
            checks++; if ({c0_rsp_valid, c1_rsp_valid} !== ((i == 0) ? 2'b00 : {!exp0, exp0}))
                begin errors++; $display("FAIL rr_rsp%0d got %b want %b", i, {c0_rsp_valid, c1_rsp_valid}, (i == 0) ? 2'b00 : {!exp0, exp0}); end
            checks++; if ({fp_c0_rsp_valid, fp_c1_rsp_valid} !== ((i == 0) ? 2'b00 : 2'b10))
                begin errors++; $display("FAIL fp_rsp%0d got %b want %b", i, {fp_c0_rsp_valid, fp_c1_rsp_valid}, (i == 0) ? 2'b00 : 2'b10); end
            @(negedge clk);
        end
        c0_valid = 1'b0;
        #1;
        checks++; if ({c0_ready, c1_ready, c1_rsp_valid} !== 3'b011)
            begin errors++; $display("FAIL rr_single got %b want 011", {c0_ready, c1_ready, c1_rsp_valid}); end
        @(negedge clk);
        idle();
        #1;
        checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b01) begin errors++; $display("FAIL rr_last_rsp got %b want 01", {c0_rsp_valid, c1_rsp_valid}); end
    endtask

    task automatic test_reset_suppress();
        @(negedge clk);
        c1_valid = 1'b1; c1_rs1 = 3'd0;
        #1;
        checks++; if (c1_ready !== 1'b1) begin errors++; $display("FAIL rs_grant got %b want 1", c1_ready); end
        @(negedge clk);
        rst = 1'b1; c1_valid = 1'b0; c0_valid = 1'b1; c0_we = 1'b1;
        #1;
        checks++; if ({c1_rsp_valid, c0_ready, rf_write_enable} !== 3'b000)
            begin errors++; $display("FAIL rs_suppress got %b want 000", {c1_rsp_valid, c0_ready, rf_write_enable}); end
        @(negedge clk);
        rst = 1'b0; c0_we = 1'b0; c1_valid = 1'b1;
        #1;
        checks++; if ({c0_ready, c1_ready, c1_rsp_valid} !== 3'b100)
            begin errors++; $display("FAIL rs_first got %b want 100", {c0_ready, c1_ready, c1_rsp_valid}); end
        @(negedge clk);
        idle();
        #1;
        checks++; if ({c0_rsp_valid, c1_rsp_valid} !== 2'b10) begin errors++; $display("FAIL rs_rsp got %b want 10", {c0_rsp_valid, c1_rsp_valid}); end
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_no_bypass();
        test_round_robin();
        test_reset_suppress();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
